// File: rtl/gsr_pkg.sv
// rtl/gsr_pkg.sv - shared state encoding for generic_shift_register
// Contents: gsr_state_e (GSR_IDLE, GSR_SHIFT)
package gsr_pkg;

  typedef enum logic {
    GSR_IDLE  = 1'b0,
    GSR_SHIFT = 1'b1
  } gsr_state_e;

endpackage

// File: rtl/gsr_bit_counter.sv
// rtl/gsr_bit_counter.sv - per-word bit counter with terminal-count flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart count at 0 (parallel load)
//   inc        : one accepted shift
//   last       : count equals WIDTH-1 (next accepted shift completes the word)
module gsr_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt;

  // The final shift wraps the count back to 0 so it never exceeds WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (inc) begin
      if (last) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign last = (bit_cnt == LAST_CNT);

endmodule

// File: rtl/generic_shift_register.sv
// rtl/generic_shift_register.sv - loadable shift register with word-complete pulse
// Optional macro GSR_HOLD_REG_EN adds a holding register for completed words.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load, load_data       : parallel load strobe and word (wins over shift_en)
//   shift_en, serial_in   : one-bit shift strobe and bit inserted at vacated end
//   serial_out            : current outgoing bit (MSB or LSB per MSB_FIRST)
//   data_out              : current register contents
//   busy                  : word partially shifted
//   word_done             : one-cycle pulse after the WIDTH-th accepted shift
//   hold_data, hold_valid : (GSR_HOLD_REG_EN) last captured completed word
//   hold_ack              : (GSR_HOLD_REG_EN) consumer releases hold_data
//   overrun               : (GSR_HOLD_REG_EN) sticky, word dropped while full
module generic_shift_register
  import gsr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             word_done
`ifdef GSR_HOLD_REG_EN
  ,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid,
  input  logic             hold_ack,
  output logic             overrun
`endif
);

  gsr_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             shift_acc;
  logic             last_bit;
  logic             word_fin;

  // Load takes priority, so a shift is only accepted without a concurrent load.
  assign shift_acc = shift_en && (state_q == GSR_SHIFT) && !load;
  assign word_fin  = shift_acc && last_bit;

  gsr_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .inc   (shift_acc),
    .last  (last_bit)
  );

  always_comb begin
    sr_d    = sr_q;
    state_d = state_q;
    if (load) begin
      sr_d    = load_data;
      state_d = GSR_SHIFT;
    end else if (shift_acc) begin
      sr_d = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], serial_in}
                              : {serial_in, sr_q[WIDTH-1:1]};
      if (last_bit) begin
        state_d = GSR_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GSR_IDLE;
      sr_q      <= '0;
      word_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      word_done <= word_fin;
    end
  end

  assign data_out   = sr_q;
  assign busy       = (state_q == GSR_SHIFT);
  assign serial_out = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

`ifdef GSR_HOLD_REG_EN
  // sr_d is the completed word on the finishing edge. An ack in the same
  // cycle frees the slot, so the new word is captured and hold_valid stays 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        overrun <= 1'b0;
      end
      if (word_fin) begin
        if (!hold_valid || hold_ack) begin
          hold_data  <= sr_d;
          hold_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hold_ack && hold_valid) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_generic_shift_register.sv
// tb/tb_generic_shift_register.sv - self-checking bench for generic_shift_register
module tb_generic_shift_register;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // DUT A: WIDTH=8, MSB first
  logic       a_load, a_shift, a_si;
  logic [7:0] a_ld_data;
  logic       a_sout, a_busy, a_done;
  logic [7:0] a_data;
`ifdef GSR_HOLD_REG_EN
  logic [7:0] a_hold_data;
  logic       a_hold_valid, a_hold_ack, a_overrun;
`endif

  // DUT B: WIDTH=16, LSB first
  logic        b_load, b_shift, b_si;
  logic [15:0] b_ld_data;
  logic        b_sout, b_busy, b_done;
  logic [15:0] b_data;
`ifdef GSR_HOLD_REG_EN
  logic [15:0] b_hold_data;
  logic        b_hold_valid, b_overrun;
  logic        b_hold_ack = 1'b0;
`endif

  generic_shift_register #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (a_load),
    .load_data  (a_ld_data),
    .shift_en   (a_shift),
    .serial_in  (a_si),
    .serial_out (a_sout),
    .data_out   (a_data),
    .busy       (a_busy),
    .word_done  (a_done)
`ifdef GSR_HOLD_REG_EN
    ,
    .hold_data  (a_hold_data),
    .hold_valid (a_hold_valid),
    .hold_ack   (a_hold_ack),
    .overrun    (a_overrun)
`endif
  );

  generic_shift_register #(.WIDTH(16), .MSB_FIRST(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (b_load),
    .load_data  (b_ld_data),
    .shift_en   (b_shift),
    .serial_in  (b_si),
    .serial_out (b_sout),
    .data_out   (b_data),
    .busy       (b_busy),
    .word_done  (b_done)
`ifdef GSR_HOLD_REG_EN
    ,
    .hold_data  (b_hold_data),
    .hold_valid (b_hold_valid),
    .hold_ack   (b_hold_ack),
    .overrun    (b_overrun)
`endif
  );

  typedef struct {
    logic       ld;
    logic [7:0] ld_data;
    logic       sh;
    logic       si;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic ld, input logic [7:0] d, input logic sh,
                              input logic si, input logic [7:0] ed, input logic eb,
                              input logic edn);
    vec_t v;
    v.ld = ld; v.ld_data = d; v.sh = sh; v.si = si;
    v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn;
    tbl.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on DUT A, queue the expectation, compare after the edge.
  task automatic apply_a(input logic ld, input logic [7:0] d, input logic sh,
                         input logic si, input logic [7:0] ed, input logic eb,
                         input logic edn, input string tag);
    exp_t e;
    a_load = ld; a_ld_data = d; a_shift = sh; a_si = si;
    e.data = ed; e.busy = eb; e.done = edn;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check({tag, " data_out"},   a_data, e.data);
    check({tag, " serial_out"}, a_sout, e.data[7]);
    check({tag, " busy"},       a_busy, e.busy);
    check({tag, " word_done"},  a_done, e.done);
    a_load = 1'b0; a_shift = 1'b0; a_si = 1'b0;
  endtask

`ifdef GSR_HOLD_REG_EN
  task automatic run_word(input logic [7:0] w, input logic ack_last);
    apply_a(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "hold load");
    for (int i = 0; i < 8; i++) begin
      a_hold_ack = ack_last && (i == 7);
      apply_a(1'b0, 8'h00, 1'b1, w[7-i], 8'(w >> (7 - i)), (i != 7), (i == 7), "hold shift");
      a_hold_ack = 1'b0;
    end
  endtask
`endif

  initial begin
    logic [15:0] m;
    int          ndone;

    rst_n = 1'b0;
    a_load = 1'b0; a_ld_data = '0; a_shift = 1'b0; a_si = 1'b0;
    b_load = 1'b0; b_ld_data = '0; b_shift = 1'b0; b_si = 1'b0;
`ifdef GSR_HOLD_REG_EN
    a_hold_ack = 1'b0;
`endif
    repeat (2) tick();
    check("reset a data_out", a_data, 8'h00);
    check("reset a busy",     a_busy, 1'b0);
    check("reset a word_done", a_done, 1'b0);
    check("reset a serial_out", a_sout, 1'b0);
    check("reset b data_out", b_data, 16'h0000);
    check("reset b busy",     b_busy, 1'b0);
    #3 rst_n = 1'b1;

    // MSB-first word, idle shifting, load priority, load on final shift
    add(1, 8'hA5, 0, 0, 8'hA5, 1, 0);
    add(0, 8'h00, 1, 1, 8'h4B, 1, 0);
    add(0, 8'h00, 1, 1, 8'h97, 1, 0);
    add(0, 8'h00, 1, 1, 8'h2F, 1, 0);
    add(0, 8'h00, 1, 1, 8'h5F, 1, 0);
    add(0, 8'h00, 1, 1, 8'hBF, 1, 0);
    add(0, 8'h00, 1, 1, 8'h7F, 1, 0);
    add(0, 8'h00, 1, 1, 8'hFF, 1, 0);
    add(0, 8'h00, 1, 1, 8'hFF, 0, 1);
    add(0, 8'h00, 0, 0, 8'hFF, 0, 0);
    add(0, 8'h00, 1, 0, 8'hFF, 0, 0);
    add(0, 8'h00, 1, 1, 8'hFF, 0, 0);
    add(1, 8'h3C, 1, 1, 8'h3C, 1, 0);
    add(0, 8'h00, 1, 0, 8'h78, 1, 0);
    add(0, 8'h00, 1, 0, 8'hF0, 1, 0);
    add(0, 8'h00, 1, 0, 8'hE0, 1, 0);
    add(0, 8'h00, 1, 0, 8'hC0, 1, 0);
    add(0, 8'h00, 1, 0, 8'h80, 1, 0);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1);
    add(1, 8'h81, 0, 0, 8'h81, 1, 0);
    add(0, 8'h00, 1, 1, 8'h03, 1, 0);
    add(0, 8'h00, 1, 1, 8'h07, 1, 0);
    add(0, 8'h00, 1, 1, 8'h0F, 1, 0);
    add(0, 8'h00, 1, 1, 8'h1F, 1, 0);
    add(0, 8'h00, 1, 1, 8'h3F, 1, 0);
    add(0, 8'h00, 1, 1, 8'h7F, 1, 0);
    add(0, 8'h00, 1, 1, 8'hFF, 1, 0);
    add(1, 8'h55, 1, 0, 8'h55, 1, 0);
    add(0, 8'h00, 1, 0, 8'hAA, 1, 0);
    add(0, 8'h00, 1, 0, 8'h54, 1, 0);
    add(0, 8'h00, 1, 0, 8'hA8, 1, 0);
    add(0, 8'h00, 1, 0, 8'h50, 1, 0);
    add(0, 8'h00, 1, 0, 8'hA0, 1, 0);
    add(0, 8'h00, 1, 0, 8'h40, 1, 0);
    add(0, 8'h00, 1, 0, 8'h80, 1, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      apply_a(tbl[i].ld, tbl[i].ld_data, tbl[i].sh, tbl[i].si,
              tbl[i].exp_data, tbl[i].exp_busy, tbl[i].exp_done, $sformatf("vec%0d", i));
    end

    // LSB-first 16-bit word with idle gaps between strobes
    b_load = 1'b1; b_ld_data = 16'h0001;
    tick();
    b_load = 1'b0;
    check("b load serial_out", b_sout, 1'b1);
    check("b load busy", b_busy, 1'b1);
    m = 16'h0001;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        tick();
        check("b gap data_out", b_data, m);
        check("b gap word_done", b_done, 1'b0);
      end
      b_shift = 1'b1; b_si = 1'b0;
      m = {1'b0, m[15:1]};
      tick();
      b_shift = 1'b0;
      if (b_done) ndone++;
      check("b shift data_out", b_data, m);
      check("b shift serial_out", b_sout, 1'b0);
      check("b shift word_done", b_done, (i == 15));
    end
    tick();
    if (b_done) ndone++;
    check("b word_done count", ndone, 1);
    check("b idle busy", b_busy, 1'b0);

`ifdef GSR_HOLD_REG_EN
    run_word(8'h11, 1'b0);
    check("hold first data", a_hold_data, 8'h11);
    check("hold first valid", a_hold_valid, 1'b1);
    check("hold first overrun", a_overrun, 1'b0);
    run_word(8'h22, 1'b0);
    check("hold overrun data", a_hold_data, 8'h11);
    check("hold overrun flag", a_overrun, 1'b1);
    run_word(8'h33, 1'b1);
    check("hold ack data", a_hold_data, 8'h33);
    check("hold ack valid", a_hold_valid, 1'b1);
    check("hold ack overrun", a_overrun, 1'b0);
    a_hold_ack = 1'b1;
    tick();
    a_hold_ack = 1'b0;
    check("hold release valid", a_hold_valid, 1'b0);
`endif

    // Reset in the middle of a word, between clock edges
    apply_a(1'b1, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, "rst load");
    apply_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h87, 1'b1, 1'b0, "rst shift1");
    apply_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, "rst shift2");
    a_shift = 1'b1; a_si = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async rst data_out", a_data, 8'h00);
    check("async rst busy", a_busy, 1'b0);
    check("async rst word_done", a_done, 1'b0);
    check("async rst serial_out", a_sout, 1'b0);
`ifdef GSR_HOLD_REG_EN
    check("async rst hold_valid", a_hold_valid, 1'b0);
    check("async rst hold_data", a_hold_data, 8'h00);
`endif
    tick();
    #4 rst_n = 1'b1;
    a_shift = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post rst word_done", a_done, 1'b0);
      check("post rst busy", a_busy, 1'b0);
      check("post rst data_out", a_data, 8'h00);
    end
    a_shift = 1'b0;
    apply_a(1'b1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, "post rst load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
